// File: rtl/sbentsrc_pkg.sv
// Shared definitions for the entropy-source controller.
// Holds the controller FSM state encoding, the alarm code values reported
// on o_alarm_code, and a small constant helper used for counter sizing.
package sbentsrc_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SRC_RST,
        WARMUP,
        COLLECT,
        HOLD,
        ALARM
    } state_t;

    typedef logic [1:0] alarm_code_t;

    localparam alarm_code_t ALARM_NONE = 2'b00;
    localparam alarm_code_t ALARM_RCT  = 2'b01;
    localparam alarm_code_t ALARM_APT  = 2'b10;

    // Length of the source reset pulse in cycles.
    localparam int unsigned SRC_RST_CYCLES = 2;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/sbentsrc_if.sv
// Output word handshake between the entropy controller and its consumer.
//   o_data  : assembled random word (held stable while o_valid is high)
//   o_valid : word available
//   i_ready : consumer accepts the word
// master = controller side, slave = consumer side.
interface sbentsrc_if #(
    parameter int unsigned OUT_WIDTH = 32
);
    logic [OUT_WIDTH-1:0] o_data;
    logic                 o_valid;
    logic                 i_ready;

    modport master (output o_data, output o_valid, input i_ready);
    modport slave  (input o_data, input o_valid, output i_ready);
endinterface

// File: rtl/sbentsrc_health.sv
// Online health tests on the raw entropy stream.
//   i_clk, i_reset    : clock, synchronous active-high reset
//   i_clear           : restart both tests (new source run)
//   i_sample          : raw sample
//   i_sample_valid    : sample is consumed this cycle
//   o_rct_fail        : repetition-count test fails on the current sample
//   o_apt_fail        : adaptive-proportion test fails on the current sample
// Fail flags are combinational on the sample being consumed so the controller
// can react on the same edge that accepts it.
module sbentsrc_health #(
    parameter int unsigned RNG_WIDTH  = 4,
    parameter int unsigned RCT_CUTOFF = 8,
    parameter int unsigned APT_WINDOW = 64,
    parameter int unsigned APT_CUTOFF = 40
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic                 i_clear,
    input  logic [RNG_WIDTH-1:0] i_sample,
    input  logic                 i_sample_valid,
    output logic                 o_rct_fail,
    output logic                 o_apt_fail
);
    localparam int unsigned RCT_W = $clog2(RCT_CUTOFF + 1);
    localparam int unsigned WIN_W = (APT_WINDOW > 1) ? $clog2(APT_WINDOW) : 1;
    localparam int unsigned APT_W = $clog2(APT_WINDOW + 1);

    logic [RNG_WIDTH-1:0] last_q;
    logic [RNG_WIDTH-1:0] ref_q;
    logic                 have_last_q;
    logic [RCT_W-1:0]     run_q, run_d;
    logic [WIN_W-1:0]     win_q;
    logic [APT_W-1:0]     hits_q, hits_d;
    logic                 win_start;
    logic                 win_end;

    always_comb begin
        run_d = RCT_W'(1);
        if (have_last_q && (i_sample == last_q)) begin
            // Saturate: an alarm stops sampling, but never wrap regardless.
            run_d = (run_q == RCT_W'(RCT_CUTOFF)) ? run_q : run_q + 1'b1;
        end
        win_start = (win_q == '0);
        win_end   = (win_q == WIN_W'(APT_WINDOW - 1));
        // The first sample of a window becomes the reference and counts once.
        hits_d = win_start ? APT_W'(1) : hits_q + APT_W'(i_sample == ref_q);
    end

    assign o_rct_fail = i_sample_valid && (32'(run_d) >= RCT_CUTOFF);
    assign o_apt_fail = i_sample_valid && (32'(hits_d) > APT_CUTOFF);

    always_ff @(posedge i_clk) begin
        if (i_reset || i_clear) begin
            last_q      <= '0;
            ref_q       <= '0;
            have_last_q <= 1'b0;
            run_q       <= '0;
            win_q       <= '0;
            hits_q      <= '0;
        end else if (i_sample_valid) begin
            last_q      <= i_sample;
            have_last_q <= 1'b1;
            run_q       <= run_d;
            hits_q      <= hits_d;
            if (win_start) begin
                ref_q <= i_sample;
            end
            win_q <= win_end ? '0 : win_q + 1'b1;
        end
    end

endmodule

// File: rtl/sbentsrc_ctrl.sv
// Entropy-source controller: resets and warms up the source, packs raw
// samples into words, and runs continuous health tests.
//   i_clk, i_reset        : clock, synchronous active-high reset
//   i_start, i_stop       : run control
//   o_src_en, o_src_reset : entropy source control
//   i_raw                 : raw sample from the source
//   bus                   : word handshake (o_data/o_valid/i_ready)
//   o_busy                : controller not idle
//   o_alarm, o_alarm_code : latched health failure and its cause
//   i_clear_alarm         : alarm acknowledge
module sbentsrc_ctrl
    import sbentsrc_pkg::*;
#(
    parameter int unsigned RNG_WIDTH     = 4,
    parameter int unsigned OUT_WIDTH     = 32,
    parameter int unsigned WARMUP_CYCLES = 64,
    parameter int unsigned RCT_CUTOFF    = 8,
    parameter int unsigned APT_WINDOW    = 64,
    parameter int unsigned APT_CUTOFF    = 40
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic                 i_start,
    input  logic                 i_stop,
    output logic                 o_src_en,
    output logic                 o_src_reset,
    input  logic [RNG_WIDTH-1:0] i_raw,
    sbentsrc_if.master           bus,
    output logic                 o_busy,
    output logic                 o_alarm,
    output logic [1:0]           o_alarm_code,
    input  logic                 i_clear_alarm
);
    localparam int unsigned N       = OUT_WIDTH / RNG_WIDTH;
    localparam int unsigned CNT_MAX = max_u(max_u(WARMUP_CYCLES, N - 1), SRC_RST_CYCLES - 1);
    localparam int unsigned CNT_W   = max_u($clog2(CNT_MAX + 1), 1);

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [OUT_WIDTH-1:0] acc_q, acc_d;
    logic [OUT_WIDTH-1:0] data_q, data_d;
    alarm_code_t          code_q, code_d;
    logic [OUT_WIDTH-1:0] acc_shift;
    logic                 sample_valid;
    logic                 health_clear;
    logic                 rct_fail;
    logic                 apt_fail;
    logic                 fail;

    // WARMUP spends its first cycle (cnt 0) letting the freshly enabled source
    // produce a registered sample; samples are consumed on cnt 1..WARMUP_CYCLES.
    assign sample_valid = ((state_q == WARMUP) && (cnt_q != '0)) || (state_q == COLLECT);
    assign health_clear = (state_q == IDLE) && i_start;
    assign fail         = rct_fail || apt_fail;
    // New sample shifts in at the bottom, so the first one ends up in the MSBs.
    assign acc_shift    = OUT_WIDTH'({acc_q, i_raw});

    sbentsrc_health #(
        .RNG_WIDTH (RNG_WIDTH),
        .RCT_CUTOFF(RCT_CUTOFF),
        .APT_WINDOW(APT_WINDOW),
        .APT_CUTOFF(APT_CUTOFF)
    ) u_health (
        .i_clk         (i_clk),
        .i_reset       (i_reset),
        .i_clear       (health_clear),
        .i_sample      (i_raw),
        .i_sample_valid(sample_valid),
        .o_rct_fail    (rct_fail),
        .o_apt_fail    (apt_fail)
    );

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            data_q  <= '0;
            code_q  <= ALARM_NONE;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            data_q  <= data_d;
            code_q  <= code_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = '0;
        acc_d   = acc_q;
        data_d  = data_q;
        code_d  = code_q;
        case (state_q)
            IDLE: begin
                if (i_start) begin
                    state_d = SRC_RST;
                    acc_d   = '0;
                end
            end
            SRC_RST: begin
                if (i_stop) begin
                    state_d = IDLE;
                end else if (cnt_q == CNT_W'(SRC_RST_CYCLES - 1)) begin
                    state_d = WARMUP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            WARMUP: begin
                if (fail) begin
                    state_d = ALARM;
                    code_d  = rct_fail ? ALARM_RCT : ALARM_APT;
                end else if (i_stop) begin
                    state_d = IDLE;
                end else if (cnt_q == CNT_W'(WARMUP_CYCLES)) begin
                    state_d = COLLECT;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            COLLECT: begin
                acc_d = acc_shift;
                if (fail) begin
                    state_d = ALARM;
                    code_d  = rct_fail ? ALARM_RCT : ALARM_APT;
                end else if (i_stop) begin
                    state_d = IDLE;
                end else if (cnt_q == CNT_W'(N - 1)) begin
                    state_d = HOLD;
                    data_d  = acc_shift;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            HOLD: begin
                // Stop with ready still completes the transfer this cycle.
                if (i_stop) begin
                    state_d = IDLE;
                end else if (bus.i_ready) begin
                    state_d = COLLECT;
                end
            end
            ALARM: begin
                if (i_clear_alarm) begin
                    state_d = IDLE;
                    code_d  = ALARM_NONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign o_src_en     = (state_q == WARMUP) || (state_q == COLLECT) || (state_q == HOLD);
    assign o_src_reset  = (state_q == SRC_RST);
    assign o_busy       = (state_q != IDLE);
    assign o_alarm      = (state_q == ALARM);
    assign o_alarm_code = code_q;
    assign bus.o_valid  = (state_q == HOLD);
    assign bus.o_data   = data_q;

endmodule

// File: doc/sbentsrc_ctrl.md
SBENTSRC_CTRL -- requirements
Module: sbentsrc_ctrl

Interface
REQ-001 Parameter RNG_WIDTH, default 4: width of one raw entropy sample.
REQ-002 Parameter OUT_WIDTH, default 32: output word width; a multiple of RNG_WIDTH; N = OUT_WIDTH/RNG_WIDTH.
REQ-003 Parameter WARMUP_CYCLES, default 64: number of discarded samples after source start.
REQ-004 Parameter RCT_CUTOFF, default 8: repetition-count alarm threshold.
REQ-005 Parameters APT_WINDOW, default 64, and APT_CUTOFF, default 40: adaptive-proportion window length and alarm threshold.
REQ-006 One clock, i_clk; reset i_reset is synchronous and active-high.
REQ-007 Ports:
- i_clk in 1: clock.
- i_reset in 1: sync reset.
- i_start in 1: start request.
- i_stop in 1: stop request.
- o_src_en out 1: entropy source enable.
- o_src_reset out 1: entropy source reset.
- i_raw in RNG_WIDTH: sampled source output.
- o_data out OUT_WIDTH: assembled word.
- o_valid out 1: word available.
- i_ready in 1: consumer accepts.
- o_busy out 1: state is not IDLE.
- o_alarm out 1: health failure latched.
- o_alarm_code out 2: 01 = RCT, 10 = APT.
- i_clear_alarm in 1: alarm acknowledge.

Function
REQ-008 FSM states: IDLE, SRC_RST, WARMUP, COLLECT, HOLD, ALARM.
REQ-009 IDLE:
- i_start=1 goes to SRC_RST.
- o_src_en=0, o_src_reset=0.
REQ-010 SRC_RST:
- Lasts exactly 2 cycles with o_src_reset=1 and o_src_en=0.
- Then goes to WARMUP.
REQ-011 WARMUP:
- o_src_en=1.
- i_raw is consumed once per cycle for WARMUP_CYCLES cycles, with samples discarded.
- Then goes to COLLECT.
REQ-012 COLLECT:
- Shifts one i_raw per cycle into the accumulator.
- The first sample lands in the most-significant RNG_WIDTH bits.
- After N samples, goes to HOLD.
REQ-013 HOLD:
- o_valid=1 and o_data is stable until i_ready=1.
- On the handshake cycle, goes to COLLECT; the source stays enabled.
REQ-014 o_valid is never high outside HOLD; o_data is don't-care-stable (holds last word) when o_valid=0.
REQ-015 Health tests consume every sample in WARMUP and COLLECT, and no sample in HOLD.
REQ-016 RCT: a run of RCT_CUTOFF consecutive equal samples raises alarm code 01.
REQ-017 APT:
- The first sample of each APT_WINDOW-sample window is the reference.
- More than APT_CUTOFF occurrences of the reference within the window raises code 10.
- Counters restart on window completion.
REQ-018 Alarm:
- On the next edge, enters ALARM with o_alarm=1, o_src_en=0, and any partial or held word discarded.
- If both tests fire in the same cycle, code=01.
REQ-019 ALARM: exits to IDLE only on i_clear_alarm=1, which also clears o_alarm and o_alarm_code; i_start is ignored.
REQ-020 i_stop=1 in SRC_RST, WARMUP, COLLECT or HOLD goes to IDLE on the next edge and discards partial or held data.
REQ-021 In HOLD, i_ready=1 together with i_stop=1 completes the transfer, then goes to IDLE.
REQ-022 Alarm outranks stop; stop outranks start; i_start outside IDLE is ignored.
REQ-023 Latency: o_valid first rises 3+WARMUP_CYCLES+N cycles after the edge sampling i_start (no alarm, no stop).
REQ-024 Health-test counters and the accumulator are cleared on entry to SRC_RST.

Reset
REQ-025 i_reset=1 at any edge (including mid-HOLD or ALARM) forces IDLE.
REQ-026 After reset: o_src_en=0, o_src_reset=0, o_valid=0, o_data=0, o_busy=0, o_alarm=0, o_alarm_code=00, and all counters=0.

Structure
REQ-027 Package sbentsrc_pkg holds the FSM state encoding and the alarm code constants (ALARM_NONE, ALARM_RCT, ALARM_APT).
REQ-028 The RCT and APT logic sit in one sub-module, sbentsrc_health (inputs: sample, sample-valid, clear; outputs: rct_fail, apt_fail).

Verification (WARMUP_CYCLES=4, N=8, RCT_CUTOFF=4, APT_WINDOW=16, APT_CUTOFF=10 unless noted)
REQ-029 Reset, then pulse i_start; i_raw gives 4 warmup values 9,A,B,C then 1..8; i_ready=1 -> o_valid rises 15 cycles after start, with o_data=0x12345678.
REQ-030 In COLLECT, i_raw=0x5 for 4 consecutive cycles -> o_alarm=1, code=01, o_src_en=0 next cycle, no o_valid; i_clear_alarm -> IDLE, o_alarm=0.
REQ-031 APT_CUTOFF=6, RCT_CUTOFF=16; stream alternating 3,7 from window start -> 7th occurrence of 3 raises code=10.
REQ-032 Hold i_ready=0 for 10 cycles in HOLD -> o_valid stays 1 and o_data is unchanged; i_ready=1 -> next word begins in COLLECT.
REQ-033 i_stop after 3 collected samples -> IDLE next edge, o_busy=0; restart yields a full fresh word.
REQ-034 i_reset asserted in HOLD -> next edge o_valid=0, o_data=0, o_src_en=0.
